// File: rtl/id_ex_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stall, taken-branch flush, memory freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module id_ex_hazard_ctrl #(
  parameter int unsigned BRANCH_PENALTY = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [31:0]      Instruction_ID,
  input  logic             UsesRs_ID,
  input  logic             UsesRt_ID,
  input  logic             MemRead_EX,
  input  logic [4:0]       WriteRegAddress_EX,
  input  logic             BranchEqual_EX,
  input  logic             Zero_EX,
  input  logic             MemBusy_MEM,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             PCSrc,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic [CNT_W-1:0] FreezeCount
);

  typedef enum logic [1:0] {StRun, StFlush, StFreeze} state_e;

  localparam logic [2:0] PenInit = 3'(BRANCH_PENALTY - 1);

  state_e     state_q, state_d;
  logic [2:0] pen_cnt_q, pen_cnt_d;
  logic [4:0] rs, rt;
  logic       taken, lu;

  assign rs    = Instruction_ID[25:21];
  assign rt    = Instruction_ID[20:16];
  assign taken = BranchEqual_EX & Zero_EX;
  // $0 is hardwired to zero, so a load "to" it never creates a dependency.
  assign lu    = MemRead_EX & (WriteRegAddress_EX != 5'd0) &
                 ((UsesRs_ID & (rs == WriteRegAddress_EX)) |
                  (UsesRt_ID & (rt == WriteRegAddress_EX)));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StRun;
      pen_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      pen_cnt_q <= pen_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pen_cnt_d = pen_cnt_q;
    unique case (state_q)
      StRun: begin
        if (MemBusy_MEM) begin
          state_d = StFreeze;
        end else if (taken && (BRANCH_PENALTY > 1)) begin
          state_d   = StFlush;
          pen_cnt_d = PenInit;
        end
      end
      StFlush: begin
        // A freeze inside the penalty window pauses the countdown without leaving FLUSH.
        if (!MemBusy_MEM) begin
          pen_cnt_d = pen_cnt_q - 3'd1;
          if (pen_cnt_q == 3'd1) state_d = StRun;
        end
      end
      StFreeze: begin
        if (!MemBusy_MEM) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IFID_Write = 1'b0;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    PCSrc      = 1'b0;
    Busy       = 1'b0;
    if (Rst) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (MemBusy_MEM) begin
            // Everything held; pending events are re-evaluated once RUN resumes.
          end else if (taken) begin
            PCWrite    = 1'b1;
            PCSrc      = 1'b1;
            IFID_Write = 1'b1;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
          end else if (lu) begin
            IDEX_Flush = 1'b1;
          end else begin
            PCWrite    = 1'b1;
            IFID_Write = 1'b1;
          end
        end
        StFlush: begin
          Busy = 1'b1;
          if (!MemBusy_MEM) begin
            PCWrite    = 1'b1;
            IFID_Write = 1'b1;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
          end
        end
        StFreeze: Busy = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_ev, flush_ev, freeze_ev;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  assign stall_ev  = (state_q == StRun) & ~MemBusy_MEM & ~taken & lu;
  assign flush_ev  = (state_q == StRun) & ~MemBusy_MEM & taken;
  assign freeze_ev = MemBusy_MEM;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (stall_ev && !(&stall_cnt_q))   stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (flush_ev && !(&flush_cnt_q))   flush_cnt_q  <= flush_cnt_q + 1'b1;
      if (freeze_ev && !(&freeze_cnt_q)) freeze_cnt_q <= freeze_cnt_q + 1'b1;
    end
  end

  assign StallCount  = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
  assign FreezeCount = freeze_cnt_q;
`else
  assign StallCount  = '0;
  assign FlushCount  = '0;
  assign FreezeCount = '0;
`endif

endmodule
